// File: rtl/light_sel_sequencer.sv
// Selector sequencer for the line-light decoders: steps sel through 0..SEL_MAX
// free-running at a prescaled rate, by single step, or by validated load.
module light_sel_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned SEL_MAX  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       dir,
  input  logic       load_valid,
  input  logic [5:0] load_sel,
  output logic       load_ready,
  output logic [5:0] sel,
  output logic       tick,
  output logic       wrapped,
  output logic       load_err,
  output logic       running
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    SEL_LAST   = 6'(SEL_MAX);

  logic          state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic          wrapped_q, wrapped_d;
  logic          load_err_q, load_err_d;
  logic          running_q, running_d;

  logic [5:0] adv_sel;
  logic       adv_wrap;
  logic       load_fire;

  assign load_ready = (state_q == ST_IDLE);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    adv_sel  = '0;
    adv_wrap = 1'b0;
    if (!dir) begin
      if (sel_q == SEL_LAST) begin
        adv_sel  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_sel = sel_q + 6'd1;
      end
    end else begin
      if (sel_q == '0) begin
        adv_sel  = SEL_LAST;
        adv_wrap = 1'b1;
      end else begin
        adv_sel = sel_q - 6'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    sel_d      = sel_q;
    tick_d     = 1'b0;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        // A presented load always shadows step, even when the code is rejected.
        if (load_fire) begin
          if (load_sel <= SEL_LAST) sel_d = load_sel;
          else                      load_err_d = 1'b1;
        end else if (step) begin
          sel_d     = adv_sel;
          tick_d    = 1'b1;
          wrapped_d = adv_wrap;
        end
        if (start && !stop) state_d = ST_RUN;
      end
      default: begin
        if (stop) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d   = '0;
          sel_d     = adv_sel;
          tick_d    = 1'b1;
          wrapped_d = adv_wrap;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      sel_q      <= '0;
      tick_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      tick_q     <= tick_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
      running_q  <= running_d;
    end
  end

  assign sel      = sel_q;
  assign tick     = tick_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;
  assign running  = running_q;

endmodule
